// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data memory responder.
// Holds the FSM state enum, the request-type encoding and the default sizing.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    localparam int DEFAULT_DEPTH   = 256;
    localparam int DEFAULT_LATENCY = 2;

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH x 32 storage with synchronous write and registered read.
// Contents are deliberately not reset.
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Latency-programmable data memory responder: captures one request, waits LATENCY
// cycles, executes it against dmem_array, then pulses ready (and err if rejected).
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        ready,
    output logic        busy,
    output logic        err,
    output state_t      o_dbg_state
);

    localparam int AW = $clog2(DEPTH);

    // Handshake: in IDLE a single strobe (memRead xor memWrite) is taken on the
    // clock edge; all inputs are then ignored while busy, and ready pulses for one
    // cycle when the request completes (err with it if the request was rejected).

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic          r_req;
    logic          r_misaligned;
    logic          r_ready;
    logic          r_err;
    logic          r_busy;
    logic [31:0]   r_rdata;

    logic          w_exec;
    logic          w_we;
    logic [AW-1:0] w_arr_addr;
    logic [31:0]   w_arr_rdata;
    logic          w_unused_addr;

    assign w_unused_addr = ^Address[31:AW+2];

    // In IDLE the array is addressed straight from the bus so that even LATENCY=1
    // has registered read data ready on the execute edge.
    assign w_arr_addr = (r_state == IDLE) ? Address[AW+1:2] : r_addr;
    assign w_exec     = (r_state == ACCESS) && (r_cnt == 4'd0);
    assign w_we       = rst && w_exec && (r_req == REQ_WRITE) && !r_misaligned;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_arr_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_req        <= REQ_READ;
            r_misaligned <= 1'b0;
            r_ready      <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_rdata      <= 32'd0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (memRead && memWrite) begin
                        r_state <= RESP;
                        r_ready <= 1'b1;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b1;
                    end else if (memRead ^ memWrite) begin
                        r_state      <= ACCESS;
                        r_cnt        <= 4'(LATENCY - 1);
                        r_addr       <= Address[AW+1:2];
                        r_wdata      <= WriteData;
                        r_req        <= memWrite ? REQ_WRITE : REQ_READ;
                        r_misaligned <= (Address[1:0] != 2'b00);
                        r_busy       <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        if ((r_req == REQ_READ) && !r_misaligned) begin
                            r_rdata <= w_arr_rdata;
                        end
                        r_state <= RESP;
                        r_ready <= 1'b1;
                        r_err   <= r_misaligned;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ReadData    = r_rdata;
    assign ready       = r_ready;
    assign busy        = r_busy;
    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit storage words; power of two.
REQ-002 Parameter LATENCY, default 2, cycles from request capture to completion; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 memRead  input  1  read request strobe from controller.
REQ-006 memWrite  input  1  write request strobe from controller.
REQ-007 Address  input  32  byte address; word index = Address[log2(DEPTH)+1:2].
REQ-008 WriteData  input  32  store data.
REQ-009 ReadData  output  32  load data; holds value of last successful read.
REQ-010 ready  output  1  one-cycle completion pulse.
REQ-011 busy  output  1  high while a request is in flight.
REQ-012 err  output  1  one-cycle pulse, coincident with ready, on a rejected request.

Function
REQ-013 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-014 In IDLE, memRead XOR memWrite high SHALL capture Address, WriteData and request type, load the latency counter with LATENCY-1, and move to ACCESS.
REQ-015 In IDLE, memRead and memWrite both high SHALL capture nothing, touch no storage, and move to RESP with error flagged.
REQ-016 A captured request with Address[1:0] != 0 SHALL be flagged misaligned; no storage write, ReadData unchanged.
REQ-017 Address bits above the index field SHALL be ignored (wrap modulo DEPTH words).
REQ-018 ACCESS SHALL decrement the counter each cycle; at counter 0 the access executes and the FSM moves to RESP.
REQ-019 Write execution SHALL update storage on that one edge only; read execution SHALL load ReadData from storage on that edge.
REQ-020 RESP SHALL last exactly one cycle: ready=1, err=1 if flagged, then return to IDLE.
REQ-021 Total latency, capture edge to ready high, SHALL be LATENCY+1 cycles; a new request is accepted in the cycle after ready.
REQ-022 busy SHALL be 1 in ACCESS and RESP, 0 in IDLE.
REQ-023 memRead/memWrite/Address/WriteData changes while busy SHALL be ignored; no queuing.
REQ-024 A read of an address written earlier SHALL return the written data; read-after-write within one transaction cannot occur.

Reset
REQ-025 rst low at a clock edge SHALL force IDLE, counter 0, ready=0, err=0, busy=0, ReadData=0.
REQ-026 Reset during ACCESS SHALL abort the request: pending write not performed, no ready pulse.
REQ-027 Storage contents SHALL not be cleared by reset.

Structure
REQ-028 Shared package dmem_pkg SHALL hold the state enum (IDLE, ACCESS, RESP), request-type constants and default DEPTH/LATENCY values.
REQ-029 Storage SHALL be a sub-module dmem_array: single-port, synchronous write, registered read, DEPTH x 32.
REQ-030 FSM, counter and capture registers SHALL live in data_mem_responder.

Verification
REQ-031 Reset, write 0xDEADBEEF at 0x10, LATENCY=2 -> busy 3 cycles, ready pulse on 3rd cycle after capture, err=0.
REQ-032 Read 0x10 after REQ-031 -> ReadData=0xDEADBEEF with ready; ReadData holds while memRead later held low.
REQ-033 memRead=memWrite=1 at 0x20 -> ready and err pulse 1 cycle later, storage at 0x20 unchanged on readback.
REQ-034 Write 0x12345678 at 0x13 -> err pulse, read 0x10 still returns 0xDEADBEEF.
REQ-035 Write 0xA5A5A5A5 at 0x400 (DEPTH=256) -> read 0x0 returns 0xA5A5A5A5 (wrap).
REQ-036 Start write 0x11111111 at 0x30, drop rst during ACCESS, release -> no ready; read 0x30 returns prior value; second memRead pulse while busy ignored.
